alu_seq: RTL

Parametrised, handshaked successor to the team's combinational 16-bit ALU. It keeps the three-operand add/sub/and/or/xor semantics and the four comparator status bits. It adds logical shifts, an iterative multiply-accumulate, registered outputs and valid/ready flow control on both sides. It sits between the register-read stage and write-back, and the control FSM stalls on `in_ready`/`out_valid`.

---
 rtl/alu_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/shift ops plus a WIDTH-cycle
// shift-add multiply-accumulate, with registered result, carry and compare flags.
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero_res,
    output logic             cout,
    output logic [3:0]       status
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic [WIDTH+1:0] sum, diff;
    logic [3:0]       status_c;
    logic             accept, is_mul, mul_last;

    assign is_mul   = (op == OP_MUL);
    assign accept   = in_valid && in_ready;
    assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign status_c = {a == b, a != b, a >= b, a < b};

    // Single-cycle datapath; two guard bits hold the carry out / borrow sign.
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        sum      = {2'b00, a} + {2'b00, b} + {2'b00, imm};
        diff     = {2'b00, a} - {2'b00, b} - {2'b00, imm};
        case (op)
            OP_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = |sum[WIDTH+1:WIDTH];
            end
            OP_SUB: begin
                alu_res  = diff[WIDTH-1:0];
                alu_cout = diff[WIDTH+1];
            end
            OP_AND:  alu_res = a & b & imm;
            OP_OR:   alu_res = a | b | imm;
            OP_XOR:  alu_res = a ^ b ^ imm;
            OP_SHL:  alu_res = a << b[SW-1:0];
            OP_SHR:  alu_res = a >> b[SW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // in_ready depends only on state and out_ready, never on in_valid.
    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = is_mul ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (mul_last) state_d = S_DONE;
            end
            S_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) state_d = is_mul ? S_MUL : S_DONE;
                    else          state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture on accept; the multiplier consumes one bit of b per MUL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            res       <= '0;
            zero_res  <= 1'b0;
            cout      <= 1'b0;
            status    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_d == S_DONE);
            if (accept) begin
                cnt    <= '0;
                mcand  <= a;
                mplier <= b;
                acc    <= imm;
                status <= status_c;
                if (!is_mul) begin
                    res      <= alu_res;
                    zero_res <= (alu_res == '0);
                    cout     <= alu_cout;
                end
            end else if (state == S_MUL) begin
                cnt    <= cnt + CW'(1);
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                if (mul_last) begin
                    res      <= acc_next;
                    zero_res <= (acc_next == '0);
                    cout     <= 1'b0;
                end
            end
        end
    end

endmodule
